// File: rtl/key_pkg.sv
// Shared constants, FSM encoding and counter-width helper for the key filter.
package key_pkg;

   localparam int unsigned DEF_CLK_HZ  = 12_000_000;
   localparam int unsigned DEF_DEB_MS  = 20;
   localparam int unsigned DEF_LONG_MS = 1000;

   typedef enum logic [1:0] {
      KEY_IDLE         = 2'd0,
      KEY_PRESS_WAIT   = 2'd1,
      KEY_PRESSED      = 2'd2,
      KEY_RELEASE_WAIT = 2'd3
   } key_state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle pulse every CLK_HZ/1000 clocks.
module tick_gen
   import key_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned DIV   = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
   localparam int unsigned CNT_W = cnt_width(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             wrap_c;

   always_comb begin
      wrap_c = (cnt_q == CNT_W'(DIV - 1));
      cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/key_filter.sv
// Per-key debounce with press/release/long-press pulses and a toggle level.
module key_filter
   import key_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned N_KEYS  = 2,
   parameter int unsigned DEB_MS  = DEF_DEB_MS,
   parameter int unsigned LONG_MS = DEF_LONG_MS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_toggle,
   output logic [N_KEYS-1:0] key_long
);

   localparam int unsigned DEB_W  = cnt_width(DEB_MS);
   localparam int unsigned LONG_W = cnt_width(LONG_MS);

   logic tick;

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      logic              sync1_q, sync2_q;
      key_state_e        state_q, state_d;
      logic [DEB_W-1:0]  deb_q, deb_d, deb_inc_c;
      logic [LONG_W-1:0] lcnt_q, lcnt_d, lcnt_inc_c;
      logic              level_q, level_d;
      logic              press_q, press_d;
      logic              rel_q, rel_d;
      logic              toggle_q, toggle_d;
      logic              long_q, long_d;

      assign deb_inc_c  = deb_q + DEB_W'(1);
      assign lcnt_inc_c = lcnt_q + LONG_W'(1);

      // Synchronizer idles released (1) so reset never looks like a press.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
         end else begin
            sync1_q <= key_in[g];
            sync2_q <= sync1_q;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q  <= KEY_IDLE;
            deb_q    <= '0;
            lcnt_q   <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            toggle_q <= 1'b0;
            long_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            deb_q    <= deb_d;
            lcnt_q   <= lcnt_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            toggle_q <= toggle_d;
            long_q   <= long_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         deb_d    = deb_q;
         lcnt_d   = lcnt_q;
         level_d  = level_q;
         press_d  = 1'b0;
         rel_d    = 1'b0;
         toggle_d = toggle_q;
         long_d   = 1'b0;

         case (state_q)
            KEY_IDLE: begin
               deb_d = '0;
               if (!sync2_q) begin
                  state_d = KEY_PRESS_WAIT;
               end
            end
            KEY_PRESS_WAIT: begin
               if (sync2_q) begin
                  state_d = KEY_IDLE;
                  deb_d   = '0;
               end else if (tick) begin
                  deb_d = deb_inc_c;
                  if (deb_inc_c == DEB_W'(DEB_MS)) begin
                     state_d  = KEY_PRESSED;
                     press_d  = 1'b1;
                     level_d  = 1'b1;
                     toggle_d = ~toggle_q;
                     lcnt_d   = '0;
                  end
               end
            end
            KEY_PRESSED: begin
               // Long counter saturates so key_long fires only once per hold.
               if (tick && (lcnt_q != LONG_W'(LONG_MS))) begin
                  lcnt_d = lcnt_inc_c;
                  long_d = (lcnt_inc_c == LONG_W'(LONG_MS));
               end
               if (sync2_q) begin
                  state_d = KEY_RELEASE_WAIT;
                  deb_d   = '0;
               end
            end
            KEY_RELEASE_WAIT: begin
               if (!sync2_q) begin
                  state_d = KEY_PRESSED;
               end else if (tick) begin
                  deb_d = deb_inc_c;
                  if (deb_inc_c == DEB_W'(DEB_MS)) begin
                     state_d = KEY_IDLE;
                     rel_d   = 1'b1;
                     level_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d = KEY_IDLE;
               deb_d   = '0;
            end
         endcase
      end

      assign key_level[g]   = level_q;
      assign key_press[g]   = press_q;
      assign key_release[g] = rel_q;
      assign key_toggle[g]  = toggle_q;
      assign key_long[g]    = long_q;
   end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter CLK_HZ, default 12000000: system clock frequency in Hz.
REQ-002 Parameter N_KEYS, default 2: number of independent keys (hold, change).
REQ-003 Parameter DEB_MS, default 20: debounce window in 1 ms ticks.
REQ-004 Parameter LONG_MS, default 1000: long-press threshold in 1 ms ticks.
REQ-005 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 key_in  input  N_KEYS  raw push-button levels, active-low (0 = pressed), asynchronous to clk.
REQ-008 key_level  output  N_KEYS  debounced level, 1 = pressed.
REQ-009 key_press  output  N_KEYS  one-cycle pulse on confirmed press.
REQ-010 key_release  output  N_KEYS  one-cycle pulse on confirmed release.
REQ-011 key_toggle  output  N_KEYS  level that flips on every confirmed press; feeds the countdown hold input.
REQ-012 key_long  output  N_KEYS  one-cycle pulse when a press has been held LONG_MS ticks.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A shared tick SHALL pulse for one cycle every CLK_HZ/1000 cycles; the tick counter SHALL wrap from CLK_HZ/1000-1 to 0.
REQ-015 Each key SHALL run its own FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-016 IDLE -> PRESS_WAIT when the synchronized level is 0; the debounce counter SHALL clear on entry.
REQ-017 In PRESS_WAIT, a sample of 1 SHALL return the FSM to IDLE with the counter cleared (bounce restarts).
REQ-018 In PRESS_WAIT, the counter SHALL increment on each tick; on reaching DEB_MS the FSM SHALL go to PRESSED.
REQ-019 On that transition, key_press SHALL pulse, key_level SHALL go 1, key_toggle SHALL flip, and the long counter SHALL clear.
REQ-020 In PRESSED, the long counter SHALL increment per tick and saturate at LONG_MS.
REQ-021 key_long SHALL pulse exactly once, in the cycle the long counter reaches LONG_MS.
REQ-022 PRESSED -> RELEASE_WAIT when the synchronized level is 1, with the debounce counter cleared.
REQ-023 In RELEASE_WAIT, a sample of 0 SHALL return the FSM to PRESSED; the long counter SHALL be kept, not cleared.
REQ-024 In RELEASE_WAIT, the counter SHALL increment per tick; on reaching DEB_MS the FSM SHALL go to IDLE.
REQ-025 On that transition, key_release SHALL pulse and key_level SHALL go 0.
REQ-026 Press latency: key_press SHALL assert between DEB_MS and DEB_MS+1 ticks (plus 2 synchronizer cycles) after key_in falls and stays low.
REQ-027 A press or release shorter than DEB_MS ticks SHALL produce no output change.
REQ-028 Keys SHALL be fully independent; simultaneous presses SHALL each produce their own pulses in the same cycle.
REQ-029 key_press and key_release SHALL never assert in the same cycle for one key.
REQ-030 Counter widths SHALL be ceil(log2(max+1)) of their limits; no counter SHALL wrap past its limit.

Reset
REQ-031 While rst=0, every FSM SHALL be IDLE and all counters 0.
REQ-032 While rst=0, the synchronizers SHALL be 1 (released) and all outputs 0, including key_toggle.
REQ-033 Reset asserted mid-press SHALL abort immediately, with no release pulse.
REQ-034 A key held through reset release SHALL be treated as a new press and confirmed after DEB_MS ticks.

Structure
REQ-035 Package key_pkg SHALL hold the FSM state encoding (2 bits) and the default constants CLK_HZ, DEB_MS and LONG_MS.
REQ-036 Sub-module tick_gen SHALL produce the 1 ms tick and be instantiated once, shared by all keys.
REQ-037 Per-key logic SHALL be a generate loop inside key_filter.

Verification (CLK_HZ=12000 -> tick every 12 cycles, DEB_MS=4, LONG_MS=10)
REQ-038 key_in[0] low for 100 cycles, then high -> exactly one key_press; key_level high ~48 cycles after the fall; key_toggle=1.
REQ-039 key_in[0] toggling every 20 cycles for 200 cycles -> no outputs change.
REQ-040 key_in[1] held low for 200 cycles -> key_press, then one key_long ~120 cycles later; no second long pulse.
REQ-041 Both keys pressed together -> key_press=2'b11 in the same cycle; two presses -> key_toggle returns to 0.
REQ-042 rst pulsed low while key_in[0] is in PRESSED -> outputs 0 asynchronously; with the key still held, key_press re-fires ~48 cycles after rst rises.
REQ-043 In PRESSED, a 20-cycle high glitch -> no key_release, and the long count continues toward key_long.
